// File: rtl/cpu_control_pkg.sv
// Shared control-path definitions for the CPU core: trap-controller states,
// the PC-source code for sequential fetch, and the mcause encoding for external interrupts.
package cpu_control_pkg;

    localparam int MAX_IRQ        = 16;
    localparam int IRQ_IDX_W      = 4;
    localparam int CAUSE_IRQ_BASE = 16;

    localparam logic [2:0] PC_SRC_PC_PLUS_4 = 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ACK     = 2'd2,
        ST_HANDLER = 2'd3
    } irq_state_e;

    // Interrupt bit set, exception code offset into the platform-defined range.
    function automatic logic [31:0] irq_cause(input logic [IRQ_IDX_W-1:0] idx);
        return 32'h8000_0000 | (32'(CAUSE_IRQ_BASE) + 32'(idx));
    endfunction

endpackage

// File: rtl/cpu_irq_priority_encoder.sv
// Fixed-priority encoder: reports the lowest-numbered asserted request line.
module cpu_irq_priority_encoder
    import cpu_control_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0]   req,
    output logic [IRQ_IDX_W-1:0] idx,
    output logic                 any
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        idx = '0;
        any = 1'b0;
        // Walking downwards lets the lowest set index overwrite the others.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IRQ_IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_interrupt_controller.sv
// External-interrupt controller: latches requests, waits for a quiet pipeline,
// then issues a single trap-entry pulse with mcause/mepc and tracks handler residency.
module cpu_interrupt_controller
    import cpu_control_pkg::*;
#(
    parameter int NUM_IRQ  = 8,
    parameter bit IRQ_EDGE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mie_global,
    input  logic [NUM_IRQ-1:0] mie_mask,
    input  logic               csr_write_e,
    input  logic               csr_write_m,
    input  logic               csr_write_w,
    input  logic [2:0]         pc_src_e,
    input  logic               stall_d,
    input  logic               valid_d,
    input  logic               valid_e,
    input  logic               valid_m,
    input  logic [31:0]        pc_f,
    input  logic [31:0]        pc_d,
    input  logic [31:0]        pc_e,
    input  logic [31:0]        pc_m,
    input  logic               mret_w,
    output logic               int_ack,
    output logic [31:0]        int_cause,
    output logic [31:0]        int_epc,
    output logic [NUM_IRQ-1:0] irq_pending,
    output logic               in_handler
);

    irq_state_e           state, state_next;
    logic [IRQ_IDX_W-1:0] idx, idx_next, enc_idx;
    logic [NUM_IRQ-1:0]   irq_q, pending, pending_next, eligible, ack_clr;
    logic [MAX_IRQ-1:0]   eligible_wide;
    logic                 enc_any, win_eligible, safe;

    assign in_handler    = (state == ST_HANDLER);
    assign eligible      = pending & mie_mask & {NUM_IRQ{mie_global & ~in_handler}};
    assign eligible_wide = MAX_IRQ'(eligible);
    assign win_eligible  = eligible_wide[idx];

    // Trap entry must not split a CSR update or race a redirect already in Execute.
    assign safe = ~csr_write_e & ~csr_write_m & ~csr_write_w
                & (pc_src_e == PC_SRC_PC_PLUS_4) & ~stall_d;

    cpu_irq_priority_encoder #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio (
        .req (eligible),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_comb begin
        ack_clr = '0;
        if (state == ST_ACK) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (idx == IRQ_IDX_W'(i)) ack_clr[i] = 1'b1;
            end
        end
    end

    // Clearing the taken bit first means a fresh edge in the ACK cycle survives.
    always_comb begin
        if (IRQ_EDGE) pending_next = (pending & ~ack_clr) | (irq & ~irq_q);
        else          pending_next = irq;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            irq_q   <= '0;
            pending <= '0;
        end else begin
            irq_q   <= irq;
            pending <= pending_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            ST_IDLE: begin
                if (enc_any) begin
                    state_next = ST_WAIT;
                    idx_next   = enc_idx;
                end
            end
            ST_WAIT: begin
                if (!enc_any) begin
                    state_next = ST_IDLE;
                end else if (!win_eligible) begin
                    idx_next = enc_idx;
                end else if (safe) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                state_next = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (mret_w) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    assign int_ack     = (state == ST_ACK);
    assign int_cause   = int_ack ? irq_cause(idx) : 32'h0;
    assign irq_pending = pending;

    // Resume at the oldest instruction still in flight.
    always_comb begin
        int_epc = 32'h0;
        if (int_ack) begin
            if (valid_m)      int_epc = pc_m;
            else if (valid_e) int_epc = pc_e;
            else if (valid_d) int_epc = pc_d;
            else              int_epc = pc_f;
        end
    end

endmodule

// File: tb/tb_cpu_interrupt_controller.sv
// Bench for cpu_interrupt_controller: an edge-mode and a level-mode instance share stimulus
// and are compared every cycle against a behavioural model, plus directed literal checks.
module tb_cpu_interrupt_controller;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq, mie_mask;
    logic         mie_global, csr_write_e, csr_write_m, csr_write_w, stall_d;
    logic [2:0]   pc_src_e;
    logic         valid_d, valid_e, valid_m, mret_w;
    logic [31:0]  pc_f, pc_d, pc_e, pc_m;

    logic         ack_e, ack_l, inh_e, inh_l;
    logic [31:0]  cause_e, cause_l, epc_e, epc_l;
    logic [N-1:0] pend_e, pend_l;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cpu_interrupt_controller #(.NUM_IRQ(N), .IRQ_EDGE(1'b1)) u_edge (
        .clk(clk), .rst(rst), .irq(irq), .mie_global(mie_global), .mie_mask(mie_mask),
        .csr_write_e(csr_write_e), .csr_write_m(csr_write_m), .csr_write_w(csr_write_w),
        .pc_src_e(pc_src_e), .stall_d(stall_d),
        .valid_d(valid_d), .valid_e(valid_e), .valid_m(valid_m),
        .pc_f(pc_f), .pc_d(pc_d), .pc_e(pc_e), .pc_m(pc_m), .mret_w(mret_w),
        .int_ack(ack_e), .int_cause(cause_e), .int_epc(epc_e),
        .irq_pending(pend_e), .in_handler(inh_e)
    );

    cpu_interrupt_controller #(.NUM_IRQ(N), .IRQ_EDGE(1'b0)) u_lvl (
        .clk(clk), .rst(rst), .irq(irq), .mie_global(mie_global), .mie_mask(mie_mask),
        .csr_write_e(csr_write_e), .csr_write_m(csr_write_m), .csr_write_w(csr_write_w),
        .pc_src_e(pc_src_e), .stall_d(stall_d),
        .valid_d(valid_d), .valid_e(valid_e), .valid_m(valid_m),
        .pc_f(pc_f), .pc_d(pc_d), .pc_e(pc_e), .pc_m(pc_m), .mret_w(mret_w),
        .int_ack(ack_l), .int_cause(cause_l), .int_epc(epc_l),
        .irq_pending(pend_l), .in_handler(inh_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Trap life cycle: quiet -> armed (waiting for a safe slot) -> firing (one cycle) -> serving.
    localparam int QUIET = 0, ARMED = 1, FIRING = 2, SERVING = 3;

    typedef struct {
        logic [N-1:0] pend;
        logic [N-1:0] prev;
        int           phase;
        int           win;
    } mstate_t;

    mstate_t ms[2];   // [0] level instance, [1] edge instance
    bit model_ready = 1'b0;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic mstate_t step(input mstate_t s, input bit edge_mode);
        mstate_t      n;
        logic [N-1:0] elig;
        bit           quiet_pipe;
        n = s;
        if (rst) begin
            n.pend = '0; n.prev = '0; n.phase = QUIET; n.win = 0;
            return n;
        end
        elig = (mie_global && s.phase != SERVING) ? (s.pend & mie_mask) : '0;
        quiet_pipe = !csr_write_e && !csr_write_m && !csr_write_w && pc_src_e == 3'd0 && !stall_d;
        case (s.phase)
            QUIET:  if (elig != 0) begin n.phase = ARMED; n.win = lowest(elig); end
            ARMED:  if (elig == 0) n.phase = QUIET;
                    else if (!elig[s.win]) n.win = lowest(elig);
                    else if (quiet_pipe) n.phase = FIRING;
            FIRING: n.phase = SERVING;
            default: if (mret_w) n.phase = QUIET;
        endcase
        if (edge_mode) begin
            n.pend = s.pend | (irq & ~s.prev);
            if (s.phase == FIRING && !(irq[s.win] && !s.prev[s.win])) n.pend[s.win] = 1'b0;
        end else begin
            n.pend = irq;
        end
        n.prev = irq;
        return n;
    endfunction

    always @(posedge clk) begin
        ms[0] <= step(ms[0], 1'b0);
        ms[1] <= step(ms[1], 1'b1);
        model_ready <= 1'b1;
    end

    task automatic compare(input string tag, input mstate_t s, input logic ack, input logic [31:0] cause,
                           input logic [31:0] epc, input logic [N-1:0] pend, input logic inh);
        bit          firing;
        logic [31:0] exp_epc;
        firing  = (s.phase == FIRING);
        exp_epc = valid_m ? pc_m : valid_e ? pc_e : valid_d ? pc_d : pc_f;
        check({tag, "_ack"},   32'(ack),  32'(firing));
        check({tag, "_cause"}, cause,     firing ? 32'h8000_0010 + 32'(s.win) : 32'h0);
        check({tag, "_epc"},   epc,       firing ? exp_epc : 32'h0);
        check({tag, "_pend"},  32'(pend), 32'(s.pend));
        check({tag, "_inh"},   32'(inh),  32'(s.phase == SERVING));
    endtask

    always @(negedge clk) begin
        if (model_ready) begin
            compare("lvl", ms[0], ack_l, cause_l, epc_l, pend_l, inh_l);
            compare("edge", ms[1], ack_e, cause_e, epc_e, pend_e, inh_e);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int budget, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            lat++;
            if (ack_e === 1'b1) seen = 1'b1;
        end
        check("ack_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int lat;
        rst = 1'b1; irq = '0; mie_global = 1'b1; mie_mask = 8'hFF;
        csr_write_e = 1'b0; csr_write_m = 1'b0; csr_write_w = 1'b0;
        pc_src_e = 3'd0; stall_d = 1'b0; mret_w = 1'b0;
        valid_d = 1'b0; valid_e = 1'b0; valid_m = 1'b0;
        pc_f = 32'h0000_0200; pc_d = 32'h0000_01FC; pc_e = 32'h0000_01F8; pc_m = 32'h0000_01F4;
        tick();
        tick();
        @(negedge clk);
        check("rst_ack", 32'(ack_e), 0);
        check("rst_cause", cause_e, 0);
        check("rst_epc", epc_e, 0);
        check("rst_pend", 32'(pend_e), 0);
        check("rst_inh", 32'(inh_e), 0);

        // Single rising edge on line 2, quiet pipeline.
        restart();
        irq = 8'h04;
        wait_ack(10, lat);
        check("a_latency", lat, 4);
        check("a_cause", cause_e, 32'h8000_0012);
        check("a_epc_pcf", epc_e, 32'h0000_0200);
        tick();
        @(negedge clk);
        check("a_pend_cleared", 32'(pend_e), 0);
        check("a_in_handler", 32'(inh_e), 1);

        // Lines 5 and 1 together: lowest first, the other after MRET.
        restart();
        valid_m = 1'b1;
        irq = 8'h22;
        wait_ack(10, lat);
        check("b_first_cause", cause_e, 32'h8000_0011);
        check("b_epc_pcm", epc_e, 32'h0000_01F4);
        tick();
        @(negedge clk);
        check("b_pend_left", 32'(pend_e), 32'h20);
        repeat (3) tick();
        mret_w = 1'b1;
        tick();
        mret_w = 1'b0;
        wait_ack(10, lat);
        check("b_second_cause", cause_e, 32'h8000_0015);
        valid_m = 1'b0;

        // CSR write in Memory holds the trap off.
        restart();
        irq = 8'h01;
        csr_write_m = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("c_hold_no_ack", 32'(ack_e), 0);
            tick();
        end
        csr_write_m = 1'b0;
        wait_ack(10, lat);
        check("c_release_latency", lat, 2);
        check("c_cause", cause_e, 32'h8000_0010);

        // EPC from Execute when Memory holds a bubble.
        restart();
        valid_d = 1'b1; valid_e = 1'b1; pc_e = 32'h0000_0104;
        irq = 8'h80;
        wait_ack(10, lat);
        check("d_epc_pce", epc_e, 32'h0000_0104);
        check("d_cause", cause_e, 32'h8000_0017);
        valid_d = 1'b0; valid_e = 1'b0; pc_e = 32'h0000_01F8;

        // Winner masked while waiting: re-pick the next eligible line.
        restart();
        stall_d = 1'b1;
        irq = 8'h06;
        tick();
        tick();
        mie_mask = 8'hFD;
        tick();
        stall_d = 1'b0;
        wait_ack(10, lat);
        check("g_latency", lat, 2);
        check("g_cause", cause_e, 32'h8000_0012);
        mie_mask = 8'hFF;

        // New edge in the ACK cycle keeps the bit; not taken until the handler returns.
        restart();
        irq = 8'h01;
        tick();
        irq = 8'h00;
        tick();
        tick();
        irq = 8'h01;
        @(negedge clk);
        check("h_ack_cycle", 32'(ack_e), 1);
        tick();
        @(negedge clk);
        check("h_set_wins", 32'(pend_e), 32'h01);
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            check("h_no_nest", 32'(ack_e), 0);
        end
        tick();
        mret_w = 1'b1;
        tick();
        mret_w = 1'b0;
        wait_ack(10, lat);
        check("h_retake_cause", cause_e, 32'h8000_0010);

        // Level line drops while a jump blocks the trap: no ack at all.
        restart();
        pc_src_e = 3'd2;
        irq = 8'h08;
        tick();
        tick();
        irq = 8'h00;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("e_lvl_no_ack", 32'(ack_l), 0);
            tick();
        end
        pc_src_e = 3'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("e_lvl_no_ack_late", 32'(ack_l), 0);
            check("e_lvl_not_handler", 32'(inh_l), 0);
            tick();
        end

        // Reset while waiting aborts the trap.
        restart();
        stall_d = 1'b1;
        irq = 8'h10;
        tick();
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("f_ack", 32'(ack_e | ack_l), 0);
        check("f_cause", cause_e | cause_l, 0);
        check("f_epc", epc_e | epc_l, 0);
        check("f_pend", 32'(pend_e | pend_l), 0);
        check("f_inh", 32'(inh_e | inh_l), 0);
        tick();
        rst = 1'b0;
        stall_d = 1'b0;
        irq = 8'h00;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
